// File: rtl/perceptron_train_core.sv
// Single-layer perceptron: serial MAC inference, step activation, and the
// perceptron learning rule applied to weights and bias one term per cycle.
module perceptron_train_core #(
  parameter int N_INPUTS = 2,
  parameter int W        = 32,
  parameter int FRAC     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUTS*W-1:0]           in_values,
  input  logic [W-1:0]                    in_expected,
  input  logic                            training,
  input  logic [W-1:0]                    learning_rate,
  output logic                            out_valid,
  output logic [W-1:0]                    out_prediction,
  output logic [W-1:0]                    out_error,
  input  logic [$clog2(N_INPUTS+1)-1:0]   wt_sel,
  output logic [W-1:0]                    wt_data,
  output logic [15:0]                     sample_count,
  output logic [1:0]                      state_dbg
);

  // Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
  // in_valid may assert at any time, in_ready is high only in IDLE and out of reset.

  localparam int IW = $clog2(N_INPUTS+1);
  localparam logic signed [W-1:0]   ONE     = W'(1) << FRAC;
  localparam logic signed [W-1:0]   ZERO    = '0;
  localparam logic signed [2*W:0]   SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0]   SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_UPDATE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] w_q [N_INPUTS];
  logic signed [W-1:0] x_q [N_INPUTS];
  logic signed [W-1:0] bias_q, acc_q, exp_q, lr_q, delta_q;
  logic                train_q;
  logic [IW-1:0]       idx_q;

  logic signed [W-1:0]   cur_w, cur_x, mul_a, mul_b;
  logic signed [2*W-1:0] mul_p, mul_s;
  logic signed [W-1:0]   mac_next, w_next, bias_next;
  logic signed [W-1:0]   act_pred, act_err, act_delta;
  logic                  act_upd;

  function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] v);
    if (v > SAT_MAX)      return {1'b0, {(W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
    else                  return v[W-1:0];
  endfunction

  function automatic logic signed [2*W:0] ext_w(input logic signed [W-1:0] v);
    return {{(W+1){v[W-1]}}, v};
  endfunction

  function automatic logic signed [2*W:0] ext_p(input logic signed [2*W-1:0] v);
    return {v[2*W-1], v};
  endfunction

  function automatic logic signed [2*W-1:0] ext_m(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  always_comb begin
    cur_w = '0;
    cur_x = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_w = w_q[k];
        cur_x = x_q[k];
      end
    end
  end

  // One shared multiplier: w*x in MAC, lr*error in ACT, delta*x in UPDATE.
  always_comb begin
    mul_a = cur_w;
    mul_b = cur_x;
    case (state_q)
      S_ACT:    begin mul_a = lr_q;    mul_b = act_err; end
      S_UPDATE: begin mul_a = delta_q; mul_b = cur_x;   end
      default:  begin mul_a = cur_w;   mul_b = cur_x;   end
    endcase
  end

  assign mul_p     = ext_m(mul_a) * ext_m(mul_b);
  assign mul_s     = mul_p >>> FRAC;
  assign mac_next  = sat(ext_w(acc_q) + ext_p(mul_s));
  assign w_next    = sat(ext_w(cur_w) + ext_p(mul_s));
  assign bias_next = sat(ext_w(bias_q) + ext_w(delta_q));
  assign act_pred  = (acc_q > ZERO) ? ONE : ZERO;
  assign act_err   = sat(ext_w(exp_q) - ext_w(act_pred));
  assign act_delta = sat(ext_p(mul_s));
  assign act_upd   = train_q && (act_err != ZERO);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid && in_ready) state_d = S_MAC;
      S_MAC:    if (idx_q == IW'(N_INPUTS-1)) state_d = S_ACT;
      S_ACT:    state_d = act_upd ? S_UPDATE : S_IDLE;
      S_UPDATE: if (idx_q == IW'(N_INPUTS)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    state_dbg = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        w_q[k] <= '0;
        x_q[k] <= '0;
      end
      bias_q         <= '0;
      acc_q          <= '0;
      exp_q          <= '0;
      lr_q           <= '0;
      delta_q        <= '0;
      train_q        <= 1'b0;
      idx_q          <= '0;
      out_valid      <= 1'b0;
      out_prediction <= '0;
      out_error      <= '0;
      sample_count   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (in_valid && in_ready) begin
          for (int k = 0; k < N_INPUTS; k++) x_q[k] <= in_values[k*W +: W];
          exp_q   <= in_expected;
          train_q <= training;
          lr_q    <= learning_rate;
          acc_q   <= bias_q;
          idx_q   <= '0;
        end
        S_MAC: begin
          acc_q <= mac_next;
          idx_q <= idx_q + IW'(1);
        end
        S_ACT: begin
          out_prediction <= act_pred;
          out_error      <= act_err;
          out_valid      <= 1'b1;
          delta_q        <= act_delta;
          idx_q          <= '0;
          if (!act_upd) sample_count <= sample_count + 16'd1;
        end
        S_UPDATE: begin
          if (idx_q == IW'(N_INPUTS)) begin
            bias_q       <= bias_next;
            sample_count <= sample_count + 16'd1;
          end else begin
            for (int k = 0; k < N_INPUTS; k++)
              if (idx_q == IW'(k)) w_q[k] <= w_next;
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wt_data = '0;
    for (int k = 0; k < N_INPUTS; k++)
      if (wt_sel == IW'(k)) wt_data = w_q[k];
    if (wt_sel == IW'(N_INPUTS)) wt_data = bias_q;
  end

endmodule

// File: tb/tb_perceptron_train_core.sv
// Directed bench for perceptron_train_core: vector tables for training and
// inference, plus hand sequences for saturation and reset during MAC.
module tb_perceptron_train_core;

  localparam int W = 32;
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] NEG1 = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*W-1:0] in_values = '0;
  logic [W-1:0]  in_expected = '0;
  logic          training = 1'b0;
  logic [W-1:0]  learning_rate = '0;
  logic          out_valid;
  logic [W-1:0]  out_prediction, out_error;
  logic [1:0]    wt_sel = '0;
  logic [W-1:0]  wt_data;
  logic [15:0]   sample_count;
  logic [1:0]    state_dbg;

  perceptron_train_core #(.N_INPUTS(2), .W(W), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_values(in_values), .in_expected(in_expected), .training(training),
    .learning_rate(learning_rate), .out_valid(out_valid),
    .out_prediction(out_prediction), .out_error(out_error),
    .wt_sel(wt_sel), .wt_data(wt_data), .sample_count(sample_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x0, x1, expv, lr;
    logic         train;
    logic [W-1:0] pred, err;
    int           rdy;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  vec_t and_tab[40];
  vec_t inf_tab[6];

  function automatic vec_t mk(input logic [W-1:0] x0, x1, expv, input logic train,
                              input logic [W-1:0] lr, pred, err, input int rdy);
    vec_t v;
    v.x0 = x0; v.x1 = x1; v.expv = expv; v.train = train; v.lr = lr;
    v.pred = pred; v.err = err; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_wt(input string name, input logic [1:0] sel, input logic [W-1:0] want);
    wt_sel = sel;
    #1;
    check(name, 64'(wt_data), 64'(want));
  endtask

  // Called and returning near a negedge.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n, ov_lat, rdy_lat, pulses;
    logic [2*W-1:0] got, e;
    n = 0; ov_lat = -1; rdy_lat = -1; pulses = 0; got = '0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 64'(in_ready), 64'(1));
      return;
    end
    in_values     = {v.x1, v.x0};
    in_expected   = v.expv;
    training      = v.train;
    learning_rate = v.lr;
    in_valid      = 1'b1;
    exp_q.push_back({v.pred, v.err});
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    in_values     = {$urandom, $urandom};
    in_expected   = $urandom;
    training      = ~v.train;
    learning_rate = $urandom;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (ov_lat < 0) begin
          ov_lat = c;
          got = {out_prediction, out_error};
        end
      end
      if (ov_lat >= 0 && in_ready) begin
        rdy_lat = c;
        break;
      end
      @(posedge clk);
    end
    e = exp_q.pop_front();
    check({tag, "_pred"}, 64'(got[2*W-1:W]), 64'(e[2*W-1:W]));
    check({tag, "_err"}, 64'(got[W-1:0]), 64'(e[W-1:0]));
    check({tag, "_ov_lat"}, 64'(ov_lat), 64'(4));
    check({tag, "_rdy_lat"}, 64'(rdy_lat), 64'(v.rdy));
    check({tag, "_pulses"}, 64'(pulses), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int e_pred[20] = '{0,0,0,0, 1,1,0,0, 0,1,1,0, 0,0,1,0, 0,1,0,1};
    int e_err[20]  = '{0,0,0,1, -1,-1,0,1, 0,-1,-1,1, 0,0,-1,1, 0,-1,0,0};
    int ov_seen;

    for (int ep = 0; ep < 10; ep++) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        logic [W-1:0] p, er;
        i  = ep*4 + k;
        p  = (i < 20) ? 32'(e_pred[i] * 65536) : ((k == 3) ? ONE : 32'h0);
        er = (i < 20) ? 32'(e_err[i] * 65536) : 32'h0;
        and_tab[i] = mk(k[1] ? ONE : 32'h0, k[0] ? ONE : 32'h0, (k == 3) ? ONE : 32'h0,
                        1'b1, ONE, p, er, (er != 0) ? 7 : 4);
      end
    end
    // Converged AND weights w=(2,1), b=-2; (ONE,0) lands exactly on acc=0.
    inf_tab[0] = mk(32'h0, 32'h0, 32'h0, 1'b0, ONE, 32'h0, 32'h0, 4);
    inf_tab[1] = mk(32'h0, ONE,   32'h0, 1'b0, ONE, 32'h0, 32'h0, 4);
    inf_tab[2] = mk(ONE,   32'h0, 32'h0, 1'b0, ONE, 32'h0, 32'h0, 4);
    inf_tab[3] = mk(ONE,   ONE,   ONE,   1'b0, ONE, ONE,   32'h0, 4);
    inf_tab[4] = mk(ONE,   ONE,   32'h0, 1'b0, ONE, ONE,   NEG1,  4);
    inf_tab[5] = mk(32'h0, ONE,   ONE,   1'b0, ONE, 32'h0, ONE,   4);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    check("reset_ready_after", 64'(in_ready), 64'(1));
    check("reset_state", 64'(state_dbg), 64'(0));
    check("reset_pred", 64'(out_prediction), 64'(0));
    check("reset_err", 64'(out_error), 64'(0));
    check("reset_count", 64'(sample_count), 64'(0));
    check_wt("reset_w0", 2'd0, 32'h0);
    check_wt("reset_bias", 2'd2, 32'h0);
    check_wt("wt_out_of_range", 2'd3, 32'h0);

    // Zero sample: no update path
    run_vec("zero", mk(32'h0, 32'h0, 32'h0, 1'b1, ONE, 32'h0, 32'h0, 4));
    check_wt("zero_w0", 2'd0, 32'h0);
    check_wt("zero_w1", 2'd1, 32'h0);
    check_wt("zero_bias", 2'd2, 32'h0);
    check("zero_count", 64'(sample_count), 64'(1));

    // Single update from reset
    do_reset();
    run_vec("one", mk(ONE, ONE, ONE, 1'b1, ONE, 32'h0, ONE, 7));
    check_wt("one_w0", 2'd0, ONE);
    check_wt("one_w1", 2'd1, ONE);
    check_wt("one_bias", 2'd2, ONE);
    check("one_count", 64'(sample_count), 64'(1));

    // AND training, 10 epochs
    do_reset();
    for (int i = 0; i < 40; i++) run_vec($sformatf("and%0d", i), and_tab[i]);
    check_wt("and_w0", 2'd0, 32'h0002_0000);
    check_wt("and_w1", 2'd1, 32'h0001_0000);
    check_wt("and_bias", 2'd2, 32'hFFFE_0000);
    check("and_count", 64'(sample_count), 64'(40));

    // Inference with training off
    for (int i = 0; i < 6; i++) run_vec($sformatf("inf%0d", i), inf_tab[i]);
    check_wt("inf_w0", 2'd0, 32'h0002_0000);
    check_wt("inf_w1", 2'd1, 32'h0001_0000);
    check_wt("inf_bias", 2'd2, 32'hFFFE_0000);
    check("inf_count", 64'(sample_count), 64'(46));

    // Saturation: build w0=0x7FFF0000 with a strongly negative bias, then overflow w0
    do_reset();
    run_vec("sat1", mk(32'h7FFF_0000, 32'h7FFF_0000, ONE, 1'b1, ONE, 32'h0, ONE, 7));
    check_wt("sat1_w0", 2'd0, 32'h7FFF_0000);
    check_wt("sat1_bias", 2'd2, ONE);
    run_vec("sat2", mk(32'h0, ONE, 32'h0, 1'b1, 32'h7FFF_FFFF, ONE, NEG1, 7));
    check_wt("sat2_w1", 2'd1, 32'hFFFF_0001);
    check_wt("sat2_bias", 2'd2, 32'h8001_0001);
    run_vec("sat3", mk(32'h0, 32'h8000_0000, 32'h0, 1'b1, ONE, ONE, NEG1, 7));
    check_wt("sat3_w1", 2'd1, 32'h7FFF_0001);
    check_wt("sat3_bias", 2'd2, 32'h8000_0001);
    run_vec("sat4", mk(ONE, 32'h0, ONE, 1'b1, 32'h7FFF_FFFF, 32'h0, ONE, 7));
    check_wt("sat4_w0", 2'd0, 32'h7FFF_FFFF);
    check_wt("sat4_w1", 2'd1, 32'h7FFF_0001);
    check_wt("sat4_bias", 2'd2, 32'h0);
    check("sat_count", 64'(sample_count), 64'(4));

    // Reset asserted while in MAC
    in_values = {ONE, ONE}; in_expected = ONE; training = 1'b1; learning_rate = ONE;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_mac", 64'(state_dbg), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 64'(in_ready), 64'(1));
    check("abort_count", 64'(sample_count), 64'(0));
    check_wt("abort_w0", 2'd0, 32'h0);
    check_wt("abort_w1", 2'd1, 32'h0);
    check_wt("abort_bias", 2'd2, 32'h0);
    ov_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("abort_no_stale_valid", 64'(ov_seen), 64'(0));
    check("abort_pred", 64'(out_prediction), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
